// File: rtl/seq_alu_accumulator.sv
// Registered accumulator ALU: single-edge ops plus an iterative shift-add multiplier.
// Operand A is Data and operand B is the low half of the accumulator, both taken at the Start edge.
module seq_alu_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   Data,
  input  logic [2:0]         Function,
  input  logic               Start,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] ALUOut
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  typedef enum logic [2:0] {
    FN_ADD   = 3'd0,
    FN_MUL   = 3'd1,
    FN_SHL   = 3'd2,
    FN_SHR   = 3'd3,
    FN_HOLD  = 3'd4,
    FN_LOAD  = 3'd5,
    FN_LOGIC = 3'd6,
    FN_CLEAR = 3'd7
  } fn_t;

  state_t           state_q;
  logic [RW-1:0]    result_q;
  logic [RW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [RW-1:0]    product_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [RW-1:0]    alu_d;
  logic [RW-1:0]    product_d;

  assign opa = Data;
  assign opb = result_q[WIDTH-1:0];

  always_comb begin
    // NOTE: alu_d gets a default before the case so no path leaves it unassigned (no latch).
    alu_d = '0;
    case (fn_t'(Function))
      FN_ADD:   alu_d = RW'(opa) + RW'(opb);
      FN_SHL:   alu_d = (32'(opa) >= 32'(RW)) ? '0 : (RW'(opb) << opa);
      FN_SHR:   alu_d = (32'(opa) >= 32'(WIDTH)) ? '0 : (RW'(opb) >> opa);
      FN_HOLD:  alu_d = result_q;
      FN_LOAD:  alu_d = RW'(opa);
      FN_LOGIC: alu_d = {opa | opb, opa ^ opb};
      default:  alu_d = '0;
    endcase
  end

  // Product including this iteration's partial term; used both to advance and to finish.
  assign product_d = product_q + (mplier_q[0] ? mcand_q : '0);

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            if (fn_t'(Function) == FN_MUL) begin
              state_q   <= MUL;
              busy_q    <= 1'b1;
              mcand_q   <= RW'(opa);
              mplier_q  <= opb;
              product_q <= '0;
              count_q   <= '0;
            end else begin
              result_q <= alu_d;
              done_q   <= 1'b1;
            end
          end
        end
        MUL: begin
          product_q <= product_d;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          count_q   <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            result_q <= product_d;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign ALUOut = result_q;

endmodule

// File: tb/tb_seq_alu_accumulator.sv
// Bench for seq_alu_accumulator: directed scenarios plus random traffic against a transaction-level model.
module tb_seq_alu_accumulator;

  localparam int WIDTH = 4;
  localparam int RW    = 2 * WIDTH;

  logic             Clock    = 1'b0;
  logic             Reset    = 1'b0;
  logic [WIDTH-1:0] Data     = '0;
  logic [2:0]       Function = '0;
  logic             Start    = 1'b0;
  logic             Busy;
  logic             Done;
  logic [RW-1:0]    ALUOut;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Model state: accumulator, outstanding multiply cycles and its eventual product.
  int exp_acc   = 0;
  int exp_busy  = 0;
  int exp_done  = 0;
  int busy_left = 0;
  int pending   = 0;
  int m_a, m_b;

  seq_alu_accumulator #(.WIDTH(WIDTH)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Data    (Data),
    .Function(Function),
    .Start   (Start),
    .Busy    (Busy),
    .Done    (Done),
    .ALUOut  (ALUOut)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_r(input int f, input int a, input int b, input int acc);
    int r;
    case (f)
      0:       r = a + b;
      2:       r = (a >= RW) ? 0 : (b << a);
      3:       r = (a >= WIDTH) ? 0 : (b >> a);
      4:       r = acc;
      5:       r = a;
      6:       r = ((a | b) << WIDTH) | (a ^ b);
      default: r = 0;
    endcase
    return r & ((1 << RW) - 1);
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      exp_acc = 0; exp_busy = 0; exp_done = 0; busy_left = 0; pending = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      exp_done = 0;
      if (busy_left == 0) begin
        exp_acc  = pending;
        exp_busy = 0;
        exp_done = 1;
      end
    end else if (Start) begin
      m_a = int'(Data);
      m_b = exp_acc % (1 << WIDTH);
      if (Function == 3'd1) begin
        pending   = m_a * m_b;
        busy_left = WIDTH;
        exp_busy  = 1;
        exp_done  = 0;
      end else begin
        exp_acc  = model_r(int'(Function), m_a, m_b, exp_acc);
        exp_done = 1;
      end
    end else begin
      exp_done = 0;
    end
  end

  always @(negedge Clock) begin
    if (cmp_en) begin
      check("aluout", 32'(ALUOut), exp_acc);
      check("busy", 32'(Busy), exp_busy);
      check("done", 32'(Done), exp_done);
    end
  end

  task automatic op(input logic [2:0] f, input logic [WIDTH-1:0] d);
    Start = 1'b1; Function = f; Data = d;
    @(posedge Clock);
    #1 Start = 1'b0;
  endtask

  int busy_cyc, done_cnt;
  logic prev_busy;

  initial begin
    // Asynchronous reset with no clock edge in between.
    #2 Reset = 1'b1;
    #1;
    check("rst_aluout", 32'(ALUOut), 32'h00);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    cmp_en = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    op(3'd5, 4'h5);
    @(negedge Clock);
    check("load5", 32'(ALUOut), 32'h05);
    check("load5_done", 32'(Done), 32'h1);
    op(3'd0, 4'hC);
    @(negedge Clock);
    check("add_carry", 32'(ALUOut), 32'h11);
    @(negedge Clock);
    check("add_done_1cyc", 32'(Done), 32'h0);

    // 0xF * 0xF with an ignored CLEAR request in the middle.
    op(3'd5, 4'hF);
    @(negedge Clock);
    check("loadF", 32'(ALUOut), 32'h0F);
    op(3'd1, 4'hF);
    busy_cyc = 0; done_cnt = 0; prev_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      if (Busy) begin
        busy_cyc++;
        check("mul_hold", 32'(ALUOut), 32'h0F);
      end
      if (Done) begin
        done_cnt++;
        check("done_with_busy_fall", 32'({prev_busy, Busy}), 32'b10);
      end
      prev_busy = Busy;
      if (i == 1) op(3'd7, 4'h0);
    end
    check("mul_busy_cycles", busy_cyc, WIDTH);
    check("mul_done_pulses", done_cnt, 1);
    check("mul_result", 32'(ALUOut), 32'hE1);

    op(3'd5, 4'h3); @(negedge Clock); check("load3", 32'(ALUOut), 32'h03);
    op(3'd2, 4'h2); @(negedge Clock); check("shl2", 32'(ALUOut), 32'h0C);
    op(3'd3, 4'h2); @(negedge Clock); check("shr2", 32'(ALUOut), 32'h03);
    op(3'd2, 4'h9); @(negedge Clock); check("shl9", 32'(ALUOut), 32'h00);
    op(3'd6, 4'h5); @(negedge Clock); check("logic", 32'(ALUOut), 32'h55);

    // Abort a multiply with reset.
    op(3'd5, 4'h3); @(negedge Clock);
    op(3'd1, 4'h7);
    repeat (2) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("abort_aluout", 32'(ALUOut), 32'h00);
    check("abort_busy", 32'(Busy), 32'h0);
    check("abort_done", 32'(Done), 32'h0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (Done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    op(3'd5, 4'h2); @(negedge Clock);
    check("load2_after_abort", 32'(ALUOut), 32'h02);

    // Random traffic, including Start during Busy and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      #1;
      Reset    = ($urandom_range(0, 249) == 0);
      Start    = $urandom_range(0, 2) != 0;
      Function = 3'($urandom_range(0, 7));
      Data     = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    end
    @(negedge Clock);
    #1;
    Reset = 1'b0;
    Start = 1'b0;
    repeat (WIDTH + 2) @(negedge Clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
